// File: rtl/serial_transmitter.sv
// serial_transmitter: UART-style frame serializer (start, DATA_W bits LSB first, optional parity, stop).
// Optional even-parity bit before the stop bit is enabled by defining PARITY_EN.
module serial_transmitter #(
    parameter int DATA_W   = 8,
    parameter int BASE_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        F,
    output logic              data,
    output logic              busy,
    output logic              word_sent
);
    localparam int CW = $clog2(BASE_DIV * 8);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, last;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [1:0]        f_q, f_d;
    logic              data_q, data_d, busy_q, busy_d, sent_q, sent_d;
`ifdef PARITY_EN
    logic              par_q, par_d;
`endif

    // Last divider count of the bit period chosen at accept time.
    assign last = CW'((BASE_DIV << f_q) - 1);

    // Next-state logic; with en low everything holds, including a pending word_sent pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        f_d     = f_q;
        data_d  = data_q;
        busy_d  = busy_q;
        sent_d  = sent_q;
`ifdef PARITY_EN
        par_d   = par_q;
`endif
        if (en) begin
            if (state_q == IDLE) begin
                if (start) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = word;
                    f_d     = F;
                    data_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef PARITY_EN
                    par_d   = ^word;
`endif
                end
            end else if (cnt_q != last) begin
                cnt_d  = cnt_q + 1'b1;
                sent_d = (state_q == STOP) && (cnt_q == last - 1'b1);
            end else begin
                cnt_d = '0;
                case (state_q)
                    START: begin
                        state_d = DATA;
                        data_d  = sh_q[0];
                    end
                    DATA: begin
                        sh_d  = sh_q >> 1;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BW'(DATA_W - 1)) begin
                            bit_d = '0;
`ifdef PARITY_EN
                            state_d = PARITY;
                            data_d  = par_q;
`else
                            state_d = STOP;
                            data_d  = 1'b1;
`endif
                        end else begin
                            data_d = sh_d[0];
                        end
                    end
                    PARITY: begin
                        state_d = STOP;
                        data_d  = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        sent_d  = 1'b0;
                        data_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    // State registers; reset aborts any frame and returns the line high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            f_q     <= '0;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            f_q     <= f_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign data      = data_q;
    assign busy      = busy_q;
    assign word_sent = sent_q;
endmodule
